// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and divider profile table for the rPLL sequencer
//
// Purpose: state encoding, divider-select profile struct, encoded profile table
//          and small constant helpers used by pll_reconfig_ctrl.
// Ports:   none (package).
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_APPLY,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } pll_state_t;

  // rPLL dynamic select codes, already in the inverted hardware encoding.
  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_profile_t;

  localparam int PLL_MAX_PROFILES = 8;

  // The rPLL select inputs count down from 64: IDSEL/FBDSEL = 64 - divider,
  // ODSEL = 64 - ODIV/2 (ODIV is always even).
  function automatic pll_profile_t pll_encode(input int idiv, input int fbdiv, input int odiv);
    pll_profile_t p;
    p.idsel  = 6'(64 - idiv);
    p.fbdsel = 6'(64 - fbdiv);
    p.odsel  = 6'(64 - odiv / 2);
    return p;
  endfunction

  function automatic int pll_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Profile 0 is the boot profile: 27 MHz / 8 * 7 -> VCO 756 MHz (ODIV 32),
  // giving ~24 MHz on CLKOUT and ~12 MHz on CLKOUTD (SDIV 2).
  localparam pll_profile_t PLL_PROFILES [PLL_MAX_PROFILES] = '{
    pll_encode(8, 7, 32),   // 0: ~24 MHz
    pll_encode(1, 2, 16),   // 1: 54 MHz
    pll_encode(4, 11, 8),   // 2: 74.25 MHz
    pll_encode(1, 4, 8),    // 3: 108 MHz
    pll_encode(1, 1, 32),   // 4: 27 MHz
    pll_encode(2, 5, 8),    // 5: 67.5 MHz
    pll_encode(1, 3, 8),    // 6: 81 MHz
    pll_encode(1, 5, 8)     // 7: 135 MHz
  };

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the asynchronous rPLL LOCK
//
// Purpose: bring pll LOCK into the crystal clock domain (2 cycles latency).
// Ports:   clk       in  crystal clock
//          rst_n     in  synchronous active-low reset
//          lock      in  raw asynchronous LOCK
//          lock_sync out synchronized LOCK
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic lock,
  output logic lock_sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta      <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      meta      <= lock;
      lock_sync <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - rPLL power-up and profile-change sequencer
//
// Purpose: drives rPLL divider selects and RESET, qualifies LOCK, and reports
//          clk_ok; accepts profile-change requests over a valid/ready port.
// Ports:   clkin          in  27 MHz crystal clock
//          rst_n          in  synchronous active-low reset
//          req_valid      in  profile-change request
//          req_profile    in  requested profile (out-of-range clamps to 0)
//          req_ready      out request accepted when high with req_valid
//          pll_lock       in  rPLL LOCK (asynchronous)
//          pll_reset      out rPLL RESET
//          idsel/fbdsel/odsel out encoded rPLL dynamic selects
//          active_profile out profile currently applied
//          clk_ok         out PLL outputs qualified
//          busy           out sequencing in progress
//          err            out sticky failure, cleared by the next accepted request
// Option:  PLL_CTRL_LOL_RECOVER_EN - loss of lock in LOCKED re-applies the
//          current profile (err set) instead of parking in FAIL.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_PROFILES  = 4,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 2700,
  parameter int SETTLE_CYCLES = 270,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                            clkin,
  input  logic                            rst_n,
  input  logic                            req_valid,
  input  logic [$clog2(NUM_PROFILES)-1:0] req_profile,
  output logic                            req_ready,
  input  logic                            pll_lock,
  output logic                            pll_reset,
  output logic [5:0]                      idsel,
  output logic [5:0]                      fbdsel,
  output logic [5:0]                      odsel,
  output logic [$clog2(NUM_PROFILES)-1:0] active_profile,
  output logic                            clk_ok,
  output logic                            busy,
  output logic                            err
);

  localparam int PW      = $clog2(NUM_PROFILES);
  localparam int CNT_MAX = pll_max(pll_max(RESET_CYCLES, LOCK_TIMEOUT),
                                   pll_max(SETTLE_CYCLES, MAX_RETRIES));
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_LIMIT  = CW'(MAX_RETRIES);
  localparam pll_profile_t  BOOT         = PLL_PROFILES[0];

  pll_state_t   state;
  logic [CW-1:0] cnt;         // reset hold in APPLY, lock run length in SETTLE
  logic [CW-1:0] tcnt;        // WAIT_LOCK time, kept across SETTLE so chatter still times out
  logic [CW-1:0] retry;
  logic [CW-1:0] retry_next;
  logic [PW-1:0] req_clamped;
  logic [PW-1:0] next_profile;
  pll_profile_t  next_sel;
  logic          lock_s;
  logic          accept;
  logic          lock_lost;
  logic          timed_out;
  logic          enter_apply;
  logic          enter_fail;

  pll_lock_sync u_lock_sync (
    .clk       (clkin),
    .rst_n     (rst_n),
    .lock      (pll_lock),
    .lock_sync (lock_s)
  );

  always_comb begin
    accept       = req_valid && req_ready && (state == ST_LOCKED || state == ST_FAIL);
    // A request in the same cycle as a lock drop wins: it re-sequences anyway.
    lock_lost    = (state == ST_LOCKED) && !lock_s && !accept;
    timed_out    = (state == ST_WAIT_LOCK) && !lock_s && (tcnt >= TIMEOUT_LAST);
    retry_next   = (retry == '1) ? retry : retry + CW'(1);
    req_clamped  = (int'(req_profile) < NUM_PROFILES) ? req_profile : '0;
    next_profile = accept ? req_clamped : active_profile;
    next_sel     = PLL_PROFILES[3'(next_profile)];
`ifdef PLL_CTRL_LOL_RECOVER_EN
    enter_apply  = accept || lock_lost || (timed_out && (retry_next < RETRY_LIMIT));
    enter_fail   = timed_out && (retry_next >= RETRY_LIMIT);
`else
    enter_apply  = accept || (timed_out && (retry_next < RETRY_LIMIT));
    enter_fail   = lock_lost || (timed_out && (retry_next >= RETRY_LIMIT));
`endif
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state          <= ST_APPLY;
      cnt            <= '0;
      tcnt           <= '0;
      retry          <= '0;
      active_profile <= '0;
      idsel          <= BOOT.idsel;
      fbdsel         <= BOOT.fbdsel;
      odsel          <= BOOT.odsel;
      pll_reset      <= 1'b1;
      clk_ok         <= 1'b0;
      busy           <= 1'b1;
      req_ready      <= 1'b0;
      err            <= 1'b0;
    end else if (enter_apply) begin
      state          <= ST_APPLY;
      cnt            <= '0;
      tcnt           <= '0;
      active_profile <= next_profile;
      idsel          <= next_sel.idsel;
      fbdsel         <= next_sel.fbdsel;
      odsel          <= next_sel.odsel;
      pll_reset      <= 1'b1;
      clk_ok         <= 1'b0;
      busy           <= 1'b1;
      req_ready      <= 1'b0;
      if (accept) begin
        retry <= '0;
        err   <= 1'b0;
      end else if (lock_lost) begin
        retry <= '0;
        err   <= 1'b1;
      end else begin
        retry <= retry_next;
      end
    end else if (enter_fail) begin
      state     <= ST_FAIL;
      retry     <= timed_out ? retry_next : retry;
      pll_reset <= 1'b1;
      clk_ok    <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
      err       <= 1'b1;
    end else begin
      case (state)
        ST_APPLY: begin
          if (cnt >= RESET_LAST) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end else begin
            // Timeout is taken above, so this never passes TIMEOUT_LAST.
            tcnt <= tcnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
          end else if (cnt >= SETTLE_LAST) begin
            state     <= ST_LOCKED;
            clk_ok    <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;  // LOCKED and FAIL hold until a request or a lock drop
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed self-checking bench for pll_reconfig_ctrl
//
// Purpose: power-up, profile change, settle glitch, loss of lock, timeout with
//          retries, request clamping and mid-sequence reset.
// Ports:   none (top-level bench).
module tb_pll_reconfig_ctrl;

  localparam int NP = 5;
  localparam logic [31:0] SEL_P0 = 32'({6'd56, 6'd57, 6'd48});
  localparam logic [31:0] SEL_P2 = 32'({6'd60, 6'd53, 6'd60});
  localparam logic [31:0] SEL_P3 = 32'({6'd63, 6'd60, 6'd60});
  localparam logic [31:0] SEL_P4 = 32'({6'd63, 6'd63, 6'd48});

  logic       clkin = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_profile;
  logic       req_ready;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [2:0] active_profile;
  logic       clk_ok, busy, err;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clkin = ~clkin;

  pll_reconfig_ctrl #(
    .NUM_PROFILES  (NP),
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .SETTLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clkin          (clkin),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_profile    (req_profile),
    .req_ready      (req_ready),
    .pll_lock       (pll_lock),
    .pll_reset      (pll_reset),
    .idsel          (idsel),
    .fbdsel         (fbdsel),
    .odsel          (odsel),
    .active_profile (active_profile),
    .clk_ok         (clk_ok),
    .busy           (busy),
    .err            (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return clk_ok;
      default: return req_ready;
    endcase
  endfunction

  // Counts clock cycles (sampled on the falling edge) until the probed output
  // reaches level; a blown limit shows up as a wrong count.
  task automatic count_until(input int sel, input logic level, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(negedge clkin);
      cnt++;
    end while (probe(sel) !== level && cnt < limit);
  endtask

  task automatic step();
    @(negedge clkin);
  endtask

  task automatic request(input logic [2:0] prof);
    req_valid   = 1'b1;
    req_profile = prof;
    pll_lock    = 1'b0;
    step();
    req_valid   = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_pll_reset"}, 32'(pll_reset), 1);
    check({pfx, "_clk_ok"},    32'(clk_ok), 0);
    check({pfx, "_busy"},      32'(busy), 1);
    check({pfx, "_req_ready"}, 32'(req_ready), 0);
    check({pfx, "_err"},       32'(err), 0);
    check({pfx, "_active"},    32'(active_profile), 0);
    check({pfx, "_selects"},   32'({idsel, fbdsel, odsel}), SEL_P0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_profile = '0; pll_lock = 1'b0;
    repeat (3) step();
    check_reset_values("rst");

    // Power-up
    rst_n = 1'b1;
    count_until(0, 1'b0, 50, n);
    check("pwr_reset_len", 32'(n), 4);
    check("pwr_busy_wait", 32'(busy), 1);
    repeat (5) step();
    pll_lock = 1'b1;
    count_until(1, 1'b1, 50, n);
    check("pwr_lock_to_clk_ok", 32'(n), 11);
    check("pwr_active", 32'(active_profile), 0);
    check("pwr_busy", 32'(busy), 0);
    check("pwr_ready", 32'(req_ready), 1);

    // Profile change to 2
    request(3'd2);
    check("chg_selects", 32'({idsel, fbdsel, odsel}), SEL_P2);
    check("chg_pll_reset", 32'(pll_reset), 1);
    check("chg_ready_drop", 32'(req_ready), 0);
    check("chg_clk_ok", 32'(clk_ok), 0);
    check("chg_active", 32'(active_profile), 2);
    count_until(0, 1'b0, 50, n);
    check("chg_reset_len", 32'(n), 4);
    pll_lock = 1'b1;
    count_until(1, 1'b1, 50, n);
    check("chg_relock", 32'(n), 11);

    // Settle glitch: one-cycle lock drop mid-settle restarts the count
    request(3'd1);
    count_until(0, 1'b0, 50, n);
    check("gl_reset_len", 32'(n), 4);
    repeat (2) step();
    pll_lock = 1'b1;
    repeat (7) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    count_until(1, 1'b1, 60, n);
    check("gl_lock_to_clk_ok", 32'(n + 8), 19);
    check("gl_active", 32'(active_profile), 1);

    // Loss of lock in LOCKED
    pll_lock = 1'b0;
    repeat (2) step();
    check("lol_clk_ok_hold", 32'(clk_ok), 1);
    step();
    check("lol_clk_ok_fall", 32'(clk_ok), 0);
    check("lol_err", 32'(err), 1);
    check("lol_pll_reset", 32'(pll_reset), 1);
`ifdef PLL_CTRL_LOL_RECOVER_EN
    check("lol_busy", 32'(busy), 1);
    check("lol_ready", 32'(req_ready), 0);
    count_until(2, 1'b1, 150, n);
    check("lol_retries_to_fail", 32'(n), 48);
    check("lol_err_sticky", 32'(err), 1);
`else
    check("lol_busy", 32'(busy), 0);
    check("lol_ready", 32'(req_ready), 1);
`endif

    // Timeout with retries, lock never comes
    request(3'd3);
    check("to_err_cleared", 32'(err), 0);
    check("to_selects", 32'({idsel, fbdsel, odsel}), SEL_P3);
    count_until(0, 1'b0, 50, n);
    check("to_apply1", 32'(n), 4);
    count_until(0, 1'b1, 50, n);
    check("to_wait1", 32'(n), 20);
    check("to_retry_ready", 32'(req_ready), 0);
    count_until(0, 1'b0, 50, n);
    check("to_apply2", 32'(n), 4);
    count_until(0, 1'b1, 50, n);
    check("to_wait2", 32'(n), 20);
    check("to_fail_err", 32'(err), 1);
    check("to_fail_ready", 32'(req_ready), 1);
    check("to_fail_busy", 32'(busy), 0);
    check("to_fail_clk_ok", 32'(clk_ok), 0);
    repeat (6) step();
    check("to_fail_hold_reset", 32'(pll_reset), 1);
    check("to_fail_hold_ready", 32'(req_ready), 1);

    // Out-of-range request clamps to profile 0
    request(3'd5);
    check("clamp_active", 32'(active_profile), 0);
    check("clamp_selects", 32'({idsel, fbdsel, odsel}), SEL_P0);
    count_until(0, 1'b0, 50, n);
    check("clamp_reset_len", 32'(n), 4);
    pll_lock = 1'b1;
    count_until(1, 1'b1, 50, n);
    check("clamp_relock", 32'(n), 11);

    // Reset during WAIT_LOCK
    request(3'd4);
    check("mid_active", 32'(active_profile), 4);
    check("mid_selects", 32'({idsel, fbdsel, odsel}), SEL_P4);
    count_until(0, 1'b0, 50, n);
    repeat (3) step();
    check("mid_in_wait", 32'(pll_reset), 0);
    rst_n = 1'b0;
    step();
    check_reset_values("mid");
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
